// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package memory_arbiter_pkg;

  localparam int unsigned NUM_REQ                = 2;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;
  localparam logic [31:0] DEFAULT_ERR_DATA       = 32'hdeadbeef;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_e;

endpackage

// File: rtl/memory_arbiter_rr_picker2.sv
// Combinational round-robin select between two requesters.
module rr_picker2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       any_o,
  output logic       grant_o
);

  // On contention the requester not granted last wins; otherwise the lone one.
  assign any_o   = |valid_i;
  assign grant_o = (&valid_i) ? ~last_i : valid_i[1];

endmodule

// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter driving a split write/read memory port,
// one op outstanding at a time, with a per-op ready timeout.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  rq_valid,
  input  logic [1:0]  rq_write,
  input  logic [31:0] rq_addr0,
  input  logic [31:0] rq_addr1,
  input  logic [31:0] rq_wdata0,
  input  logic [31:0] rq_wdata1,
  output logic [1:0]  rq_ready,
  output logic [31:0] rq_rdata,
  output logic [31:0] in_addr,
  output logic [31:0] in_data,
  output logic        in_valid,
  input  logic        in_ready,
  output logic [31:0] out_addr,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] out_data,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;   // current / last granted requester
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic pick_any;
  logic pick;

  rr_picker2 u_picker (
    .valid_i (rq_valid),
    .last_i  (grant_q),
    .any_o   (pick_any),
    .grant_o (pick)
  );

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          addr_d  = pick ? rq_addr1 : rq_addr0;
          wdata_d = pick ? rq_wdata1 : rq_wdata0;
          rdata_d = '0;
          cnt_d   = '0;
          state_d = rq_write[pick] ? WRITE : READ;
        end
      end
      WRITE: begin
        if (in_ready) begin
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ: begin
        if (out_ready) begin
          rdata_d = out_data;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Address/data come straight from the latched registers, so they hold for the whole op.
  assign in_addr   = addr_q;
  assign in_data   = wdata_q;
  assign out_addr  = addr_q;
  assign in_valid  = (state_q == WRITE);
  assign out_valid = (state_q == READ);
  assign rq_ready  = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rq_rdata  = rdata_q;
  assign err       = err_q;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, max cycles a memory op may wait for ready before abort.
REQ-002 Parameter: ERR_DATA, 32'hdeadbeef, rdata returned on an aborted read.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 rq_valid[1:0]  input  2  per-requester request strobe; held until matching rq_ready.
REQ-007 rq_write[1:0]  input  2  1 = write, 0 = read.
REQ-008 rq_addr0, rq_addr1  input  32 each  byte address.
REQ-009 rq_wdata0, rq_wdata1  input  32 each  write data.
REQ-010 rq_ready[1:0]  output  2  one-cycle completion pulse per requester.
REQ-011 rq_rdata  output  32  read data, valid while corresponding rq_ready high.
REQ-012 in_addr, in_data  output  32 each  memory write address/data.
REQ-013 in_valid  output  1  memory write request.
REQ-014 in_ready  input  1  memory write completion.
REQ-015 out_addr  output  32  memory read address.
REQ-016 out_valid  output  1  memory read request.
REQ-017 out_ready  input  1  memory read completion.
REQ-018 out_data  input  32  memory read data, valid with out_ready.
REQ-019 err  output  1  sticky timeout flag.

Function
REQ-020 FSM states: IDLE, WRITE, READ, DONE; exactly one memory op outstanding at any time.
REQ-021 IDLE: if any rq_valid, grant one requester, latch its write/addr/wdata, go to WRITE or READ per rq_write; else stay.
REQ-022 Arbitration: round-robin; requester not granted last wins when both valid; after reset requester 0 has priority.
REQ-023 WRITE: in_valid=1 with latched addr/data, out_valid=0; on in_ready sampled high go to DONE.
REQ-024 READ: out_valid=1 with latched addr, in_valid=0; on out_ready sampled high latch out_data, go to DONE.
REQ-025 Memory addr/data outputs stable for the entire WRITE/READ state.
REQ-026 DONE: in_valid=out_valid=0, rq_ready[grant]=1 for exactly one cycle, rq_rdata = latched data (0 for writes), next state IDLE.
REQ-027 Latency: request sampled at edge E -> memory valid from E+1 -> memory ready at edge M -> rq_ready during cycle after M; memory valid always low for at least one cycle between ops.
REQ-028 Timeout: counter cleared on entering WRITE/READ, increments each cycle there; reaching TIMEOUT_CYCLES without ready -> DONE, rdata=ERR_DATA for reads, err set.
REQ-029 err stays 1 until reset; arbitration continues normally after a timeout.
REQ-030 Requester dropping rq_valid mid-op: op still completes, rq_ready still pulses.
REQ-031 A requester re-asserting immediately after its pulse competes in the following IDLE under REQ-022.
REQ-032 Memory ready arriving outside WRITE/READ is ignored.

Reset
REQ-033 Reset asynchronously forces IDLE, in_valid=out_valid=0, rq_ready=0, rq_rdata=0, err=0, timeout counter=0, last-grant=1 (requester 0 next).
REQ-034 Reset mid-op abandons the op with no rq_ready pulse; in_addr/in_data/out_addr reset to 0.

Structure
REQ-035 Shared package memory_arbiter_pkg holds the state enum, requester count (2), default TIMEOUT_CYCLES and ERR_DATA.
REQ-036 Sub-module rr_picker2: combinational round-robin select from rq_valid and last-grant; all registers stay in memory_arbiter.

Verification
REQ-037 Single write: rq0 write addr 36 data 32'hefefefef, 1-cycle memory -> in_valid one op, rq_ready[0] pulse once, memory holds value.
REQ-038 Contention: rq0 read 40, rq1 read 36 asserted same cycle after reset -> rq0 served first, rq1 second, rdata 32'hc3c3c3c3 then 32'hefefefef.
REQ-039 Fairness: both requesters continuously valid for 6 ops -> grants alternate 0,1,0,1,0,1.
REQ-040 Slow memory: read 32 with out_ready after 4 cycles -> out_addr stable throughout, rq_ready 1 cycle after out_ready, rdata 32'h35353535.
REQ-041 Timeout: memory never asserts out_ready, TIMEOUT_CYCLES=8 -> rq_ready after 8 cycles in READ, rdata 32'hdeadbeef, err=1 until reset.
REQ-042 Reset mid-read: reset asserted during READ -> out_valid=0 immediately, no rq_ready pulse, next request served normally.
